// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types for the writeback stage (width, load funct3, states).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// Module : load_extract
// Brief  : Combinational load alignment, sign/zero extension and fault check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extract
    import wb_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_value,
    output logic            o_fault
);

    logic [XLEN-1:0] w_field;

    assign w_field = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_value = '0;
        o_fault = 1'b0;
        case (i_funct3)
            F3_LB:  o_value = {{56{w_field[7]}}, w_field[7:0]};
            F3_LH: begin
                o_value = {{48{w_field[15]}}, w_field[15:0]};
                o_fault = i_addr_lo[0];
            end
            F3_LW: begin
                o_value = {{32{w_field[31]}}, w_field[31:0]};
                o_fault = |i_addr_lo[1:0];
            end
            F3_LD: begin
                o_value = w_field;
                o_fault = |i_addr_lo;
            end
            F3_LBU: o_value = {56'd0, w_field[7:0]};
            F3_LHU: begin
                o_value = {48'd0, w_field[15:0]};
                o_fault = i_addr_lo[0];
            end
            F3_LWU: begin
                o_value = {32'd0, w_field[31:0]};
                o_fault = |i_addr_lo[1:0];
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module : writeback_stage
// Brief  : Final pipeline stage driving the register-file write port; waits
//          for load data, extracts it and suppresses zero-reg/faulting writes.
//          Optional bypass/pending-load outputs under `WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int         XLEN     = 64,
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef WB_BYPASS_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            pend_valid,
    output logic [4:0]      pend_rd,
`endif
    output logic [4:0]      wa3,
    output logic            we3,
    output logic [XLEN-1:0] wd3,
    output logic            wb_fault
);

    import wb_pkg::*;

    wb_state_e       r_state;
    wb_state_e       w_state_nxt;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [2:0]      r_addr_lo;
    logic            r_reg_write;
    logic [4:0]      r_wa3;
    logic            r_we3;
    logic [XLEN-1:0] r_wd3;
    logic            r_fault;

    logic            w_xfer;
    logic            w_ld_done;
    logic [XLEN-1:0] w_ld_value;
    logic            w_ld_fault;

    assign in_ready  = (r_state == IDLE);
    assign w_xfer    = in_valid && in_ready && !flush;
    // flush beats a same-cycle response: the load is dropped without a write
    assign w_ld_done = (r_state == WAIT_MEM) && mem_rvalid && !flush;

    load_extract u_load_extract (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (mem_rdata),
        .o_value   (w_ld_value),
        .o_fault   (w_ld_fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_xfer && in_is_load)   w_state_nxt = WAIT_MEM;
            WAIT_MEM: if (flush || mem_rvalid)    w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd        <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_reg_write <= 1'b0;
        end else if (w_xfer && in_is_load) begin
            r_rd        <= in_rd;
            r_funct3    <= in_funct3;
            r_addr_lo   <= in_addr_lo;
            r_reg_write <= in_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wa3   <= '0;
            r_we3   <= 1'b0;
            r_wd3   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_we3   <= 1'b0;
            r_fault <= 1'b0;
            if (w_xfer && !in_is_load) begin
                r_we3 <= in_reg_write && (in_rd != ZERO_REG);
                r_wa3 <= in_rd;
                r_wd3 <= in_alu_result;
            end else if (w_ld_done) begin
                r_we3   <= !w_ld_fault && r_reg_write && (r_rd != ZERO_REG);
                r_wa3   <= r_rd;
                r_wd3   <= w_ld_value;
                r_fault <= w_ld_fault;
            end
        end
    end

    assign wa3      = r_wa3;
    assign we3      = r_we3;
    assign wd3      = r_wd3;
    assign wb_fault = r_fault;

`ifdef WB_BYPASS_EN
    assign fwd_valid  = r_we3;
    assign fwd_rd     = r_wa3;
    assign fwd_data   = r_wd3;
    assign pend_valid = (r_state == WAIT_MEM);
    assign pend_rd    = r_rd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module : tb_writeback_stage
// Brief  : Directed + randomized bench for writeback_stage against a
//          transaction-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [2:0]  in_addr_lo = '0;
    logic [63:0] in_alu_result = '0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic [4:0]  wa3;
    logic        we3;
    logic [63:0] wd3;
    logic        wb_fault;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: at most one load outstanding
    bit          m_pend = 0;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [2:0]  m_addr;
    bit          m_rw;

    writeback_stage #(.XLEN(64), .ZERO_REG(5'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wa3           (wa3),
        .we3           (we3),
        .wd3           (wd3),
        .wb_fault      (wb_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_load(input logic [2:0] f3, input logic [2:0] a,
                                     input logic [63:0] d, output logic [63:0] v,
                                     output bit flt);
        int          nbytes;
        logic [63:0] mask;
        logic [63:0] raw;
        nbytes = 1 << (f3 & 3'd3);
        flt    = (f3 == 3'd7) || ((int'(a) % nbytes) != 0);
        raw    = d >> (8 * int'(a));
        mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
        v      = raw & mask;
        if (f3 < 3'd3 && raw[8 * nbytes - 1]) v = v | ~mask;
    endfunction

    task automatic step(input string tag);
        bit          e_we  = 0;
        bit          e_flt = 0;
        logic [4:0]  e_wa  = '0;
        logic [63:0] e_wd  = '0;
        logic [63:0] v;
        bit          f;
        if (!m_pend) begin
            if (in_valid && !flush) begin
                if (in_is_load) begin
                    m_pend = 1; m_rd = in_rd; m_f3 = in_funct3;
                    m_addr = in_addr_lo; m_rw = in_reg_write;
                end else begin
                    e_we = in_reg_write && (in_rd != 5'd0);
                    e_wa = in_rd;
                    e_wd = in_alu_result;
                end
            end
        end else if (flush) begin
            m_pend = 0;
        end else if (mem_rvalid) begin
            ref_load(m_f3, m_addr, mem_rdata, v, f);
            m_pend = 0;
            if (f) e_flt = 1;
            else begin
                e_we = m_rw && (m_rd != 5'd0);
                e_wa = m_rd;
                e_wd = v;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s/we3", tag), {63'd0, we3}, {63'd0, e_we});
        chk($sformatf("%s/fault", tag), {63'd0, wb_fault}, {63'd0, e_flt});
        chk($sformatf("%s/ready", tag), {63'd0, in_ready}, {63'd0, !m_pend});
        if (e_we) begin
            chk($sformatf("%s/wa3", tag), {59'd0, wa3}, {59'd0, e_wa});
            chk($sformatf("%s/wd3", tag), wd3, e_wd);
        end
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; mem_rvalid = 0;
    endtask

    task automatic issue(input bit ld, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [2:0] a, input logic [63:0] alu);
        in_valid = 1; in_is_load = ld; in_rd = rd; in_funct3 = f3;
        in_addr_lo = a; in_alu_result = alu; in_reg_write = 1;
        flush = 0; mem_rvalid = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s/we3", tag), {63'd0, we3}, 64'd0);
        chk($sformatf("%s/wa3", tag), {59'd0, wa3}, 64'd0);
        chk($sformatf("%s/wd3", tag), wd3, 64'd0);
        chk($sformatf("%s/fault", tag), {63'd0, wb_fault}, 64'd0);
        chk($sformatf("%s/ready", tag), {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1;

        // reset in the middle of a load
        issue(1, 5'd5, 3'd3, 3'd0, '0);
        step("rml_acc");
        idle();
        step("rml_wait");
        #2 rst_n = 0;
        #1 chk_reset_outputs("rml_rst");
        m_pend = 0;
        @(posedge clk); #1 rst_n = 1;
        mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step("rml_rv");
        idle();
        step("rml_after");

        // ALU back-to-back
        issue(0, 5'd3, 3'd0, 3'd0, 64'h11);
        step("alu0");
        issue(0, 5'd4, 3'd0, 3'd0, 64'h22);
        step("alu1");
        idle();
        step("alu_idle");

        // LB sign extension, response three cycles after accept
        issue(1, 5'd7, 3'd0, 3'd3, '0);
        step("lb_acc");
        idle();
        step("lb_w1");
        step("lb_w2");
        mem_rvalid = 1; mem_rdata = 64'h0000_0000_8000_0000;
        step("lb_rv");
        chk("lb_value", wd3, 64'hFFFF_FFFF_FFFF_FF80);
        idle();

        // LWU
        issue(1, 5'd9, 3'd6, 3'd4, '0);
        step("lwu_acc");
        idle();
        mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_0000_0000;
        step("lwu_rv");
        chk("lwu_value", wd3, 64'h0000_0000_DEAD_BEEF);
        idle();

        // misaligned LH
        issue(1, 5'd10, 3'd1, 3'd1, '0);
        step("lh_acc");
        idle();
        mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step("lh_rv");
        idle();
        step("lh_after");

        // zero-register write suppression
        issue(0, 5'd0, 3'd0, 3'd0, '1);
        step("zero");
        idle();
        // flush races a load response
        issue(1, 5'd12, 3'd3, 3'd0, '0);
        step("fl_acc");
        idle();
        flush = 1; mem_rvalid = 1; mem_rdata = 64'hCAFE;
        step("fl_race");
        idle();
        step("fl_after");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 1) == 1);
            in_is_load    = ($urandom_range(0, 1) == 1);
            in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            in_reg_write  = ($urandom_range(0, 5) != 0);
            in_funct3     = 3'($urandom);
            in_addr_lo    = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom);
            in_alu_result = {$urandom, $urandom};
            mem_rvalid    = ($urandom_range(0, 2) == 0);
            mem_rdata     = {$urandom, $urandom};
            flush         = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
